// File: rtl/mac_pe_stream.sv
// Streaming multiply-accumulate PE for the systolic array. A moves west->east and B moves north->south.
// Each accepted pair is multiplied, then accumulated; the dot product is emitted on C at the vector's last beat.
module mac_pe_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a_in_data,
  input  logic                  a_in_valid,
  input  logic                  a_in_last,
  output logic                  a_in_ready,
  input  logic [DATA_WIDTH-1:0] b_in_data,
  input  logic                  b_in_valid,
  input  logic                  b_in_last,
  output logic                  b_in_ready,
  output logic [DATA_WIDTH-1:0] a_out_data,
  output logic                  a_out_valid,
  output logic                  a_out_last,
  input  logic                  a_out_ready,
  output logic [DATA_WIDTH-1:0] b_out_data,
  output logic                  b_out_valid,
  output logic                  b_out_last,
  input  logic                  b_out_ready,
  output logic [ACC_WIDTH-1:0]  c_out_data,
  output logic                  c_out_valid,
  input  logic                  c_out_ready,
  output logic                  last_err,
  output logic                  busy,
  output logic                  dbg_state_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  generate
    if (ACC_WIDTH < PW) begin : g_width_check
      $error("mac_pe_stream: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end
  endgenerate

  // Handshakes: a beat transfers on a port when its valid and ready are both high in the same cycle.
  // Ready never depends on valid, and A and B are only ever accepted together as a pair.

  logic [DATA_WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic                  a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic                  a_last_q, a_last_d, b_last_q, b_last_d;
  logic [PW-1:0]         p_q, p_d;
  logic                  p_valid_q, p_valid_d, p_last_q, p_last_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, c_data_q, c_data_d;
  logic                  c_valid_q, c_valid_d;
  logic                  last_err_q, last_err_d;
  logic [0:0]            state_q, state_d;

  logic                  fwd_free, c_free, stall, fire, fire_last;
  logic [PW-1:0]         prod_u, prod;
  logic signed [PW-1:0]  prod_s;
  logic [ACC_WIDTH-1:0]  p_ext, acc_sum;

  assign fwd_free   = (~a_valid_q | a_out_ready) & (~b_valid_q | b_out_ready);
  assign c_free     = ~c_valid_q | c_out_ready;
  assign stall      = p_valid_q & p_last_q & ~c_free;
  assign a_in_ready = fwd_free & ~stall;
  assign b_in_ready = fwd_free & ~stall;
  assign fire       = a_in_valid & b_in_valid & a_in_ready & b_in_ready;
  assign fire_last  = a_in_last | b_in_last;

  assign prod_u  = PW'(a_in_data) * PW'(b_in_data);
  assign prod_s  = PW'($signed(a_in_data)) * PW'($signed(b_in_data));
  assign prod    = SIGNED ? prod_s : prod_u;
  // Extend the product to accumulator width before adding; the sum wraps.
  assign p_ext   = SIGNED ? ACC_WIDTH'($signed(p_q)) : ACC_WIDTH'(p_q);
  assign acc_sum = acc_q + p_ext;

  always_comb begin
    a_data_d   = a_data_q;
    a_last_d   = a_last_q;
    a_valid_d  = a_valid_q & ~a_out_ready;
    b_data_d   = b_data_q;
    b_last_d   = b_last_q;
    b_valid_d  = b_valid_q & ~b_out_ready;
    p_d        = p_q;
    p_last_d   = p_last_q;
    p_valid_d  = stall ? p_valid_q : 1'b0;
    acc_d      = acc_q;
    c_data_d   = c_data_q;
    c_valid_d  = c_valid_q & ~c_out_ready;
    last_err_d = last_err_q;
    state_d    = state_q;
    if (fire) begin
      a_data_d  = a_in_data;
      a_last_d  = a_in_last;
      a_valid_d = 1'b1;
      b_data_d  = b_in_data;
      b_last_d  = b_in_last;
      b_valid_d = 1'b1;
      p_d       = prod;
      p_valid_d = 1'b1;
      p_last_d  = fire_last;
      state_d   = fire_last ? IDLE : ACCUM;
      if (a_in_last != b_in_last) last_err_d = 1'b1;
    end
    // A last product waits in stage 1 until the C register can take the result.
    if (p_valid_q && !p_last_q) begin
      acc_d = acc_sum;
    end else if (p_valid_q && p_last_q && c_free) begin
      c_data_d  = acc_sum;
      c_valid_d = 1'b1;
      acc_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_data_q   <= '0;
      a_last_q   <= 1'b0;
      a_valid_q  <= 1'b0;
      b_data_q   <= '0;
      b_last_q   <= 1'b0;
      b_valid_q  <= 1'b0;
      p_q        <= '0;
      p_last_q   <= 1'b0;
      p_valid_q  <= 1'b0;
      acc_q      <= '0;
      c_data_q   <= '0;
      c_valid_q  <= 1'b0;
      last_err_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      a_data_q   <= a_data_d;
      a_last_q   <= a_last_d;
      a_valid_q  <= a_valid_d;
      b_data_q   <= b_data_d;
      b_last_q   <= b_last_d;
      b_valid_q  <= b_valid_d;
      p_q        <= p_d;
      p_last_q   <= p_last_d;
      p_valid_q  <= p_valid_d;
      acc_q      <= acc_d;
      c_data_q   <= c_data_d;
      c_valid_q  <= c_valid_d;
      last_err_q <= last_err_d;
      state_q    <= state_d;
    end
  end

  assign a_out_data  = a_data_q;
  assign a_out_valid = a_valid_q;
  assign a_out_last  = a_last_q;
  assign b_out_data  = b_data_q;
  assign b_out_valid = b_valid_q;
  assign b_out_last  = b_last_q;
  assign c_out_data  = c_data_q;
  assign c_out_valid = c_valid_q;
  assign last_err    = last_err_q;
  assign busy        = (state_q == ACCUM) | p_valid_q | c_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_pe_stream.sv
// Directed bench for mac_pe_stream: an unsigned 16/40 instance and a signed 8/16 instance.
// Expected values are hand-computed dot products and handshake states.
module tb_mac_pe_stream;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Unsigned instance: DATA_WIDTH=16, ACC_WIDTH=40
  logic [15:0] u_a_in_data, u_b_in_data, u_a_out_data, u_b_out_data;
  logic        u_a_in_valid, u_a_in_last, u_a_in_ready, u_b_in_valid, u_b_in_last, u_b_in_ready;
  logic        u_a_out_valid, u_a_out_last, u_a_out_ready, u_b_out_valid, u_b_out_last, u_b_out_ready;
  logic [39:0] u_c_out_data;
  logic        u_c_out_valid, u_c_out_ready, u_last_err, u_busy, u_dbg_state;

  // Signed instance: DATA_WIDTH=8, ACC_WIDTH=16
  logic [7:0]  s_a_in_data, s_b_in_data, s_a_out_data, s_b_out_data;
  logic        s_a_in_valid, s_a_in_last, s_a_in_ready, s_b_in_valid, s_b_in_last, s_b_in_ready;
  logic        s_a_out_valid, s_a_out_last, s_a_out_ready, s_b_out_valid, s_b_out_last, s_b_out_ready;
  logic [15:0] s_c_out_data;
  logic        s_c_out_valid, s_c_out_ready, s_last_err, s_busy, s_dbg_state;

  mac_pe_stream #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .a_in_data(u_a_in_data), .a_in_valid(u_a_in_valid), .a_in_last(u_a_in_last), .a_in_ready(u_a_in_ready),
    .b_in_data(u_b_in_data), .b_in_valid(u_b_in_valid), .b_in_last(u_b_in_last), .b_in_ready(u_b_in_ready),
    .a_out_data(u_a_out_data), .a_out_valid(u_a_out_valid), .a_out_last(u_a_out_last), .a_out_ready(u_a_out_ready),
    .b_out_data(u_b_out_data), .b_out_valid(u_b_out_valid), .b_out_last(u_b_out_last), .b_out_ready(u_b_out_ready),
    .c_out_data(u_c_out_data), .c_out_valid(u_c_out_valid), .c_out_ready(u_c_out_ready),
    .last_err(u_last_err), .busy(u_busy), .dbg_state_o(u_dbg_state)
  );

  mac_pe_stream #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst(rst),
    .a_in_data(s_a_in_data), .a_in_valid(s_a_in_valid), .a_in_last(s_a_in_last), .a_in_ready(s_a_in_ready),
    .b_in_data(s_b_in_data), .b_in_valid(s_b_in_valid), .b_in_last(s_b_in_last), .b_in_ready(s_b_in_ready),
    .a_out_data(s_a_out_data), .a_out_valid(s_a_out_valid), .a_out_last(s_a_out_last), .a_out_ready(s_a_out_ready),
    .b_out_data(s_b_out_data), .b_out_valid(s_b_out_valid), .b_out_last(s_b_out_last), .b_out_ready(s_b_out_ready),
    .c_out_data(s_c_out_data), .c_out_valid(s_c_out_valid), .c_out_ready(s_c_out_ready),
    .last_err(s_last_err), .busy(s_busy), .dbg_state_o(s_dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic s_beat(input logic [7:0] a, input logic [7:0] b, input logic la, input logic lb);
    s_a_in_data  = a;
    s_b_in_data  = b;
    s_a_in_last  = la;
    s_b_in_last  = lb;
    s_a_in_valid = 1'b1;
    s_b_in_valid = 1'b1;
    step();
  endtask

  task automatic s_idle();
    s_a_in_valid = 1'b0;
    s_b_in_valid = 1'b0;
    s_a_in_last  = 1'b0;
    s_b_in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    u_a_in_data = '0; u_b_in_data = '0;
    u_a_in_valid = 1'b0; u_b_in_valid = 1'b0; u_a_in_last = 1'b0; u_b_in_last = 1'b0;
    u_a_out_ready = 1'b1; u_b_out_ready = 1'b1; u_c_out_ready = 1'b1;
    s_a_in_data = '0; s_b_in_data = '0;
    s_idle();
    s_a_out_ready = 1'b1; s_b_out_ready = 1'b1; s_c_out_ready = 1'b1;
    repeat (3) step();

    // Reset values
    chk("rst_u_c_valid", u_c_out_valid, 0);
    chk("rst_u_c_data", u_c_out_data, 0);
    chk("rst_u_a_out_valid", u_a_out_valid, 0);
    chk("rst_u_busy", u_busy, 0);
    chk("rst_u_in_ready", u_a_in_ready, 1);
    chk("rst_s_last_err", s_last_err, 0);
    rst = 1'b0;
    step();

    // Unsigned 4-beat dot product: 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin
      u_a_in_data  = 16'(i + 1);
      u_b_in_data  = 16'(i + 5);
      u_a_in_last  = (i == 3);
      u_b_in_last  = (i == 3);
      u_a_in_valid = 1'b1;
      u_b_in_valid = 1'b1;
      #1;
      chk("u_in_ready", u_b_in_ready, 1);
      step();
      chk("u_fwd_a", u_a_out_data, 64'(i + 1));
      chk("u_fwd_b", u_b_out_data, 64'(i + 5));
      chk("u_fwd_last", u_a_out_last, (i == 3) ? 64'd1 : 64'd0);
      chk("u_fwd_valid", u_b_out_valid, 1);
    end
    u_a_in_valid = 1'b0; u_b_in_valid = 1'b0; u_a_in_last = 1'b0; u_b_in_last = 1'b0;
    chk("u_c_not_yet", u_c_out_valid, 0);
    chk("u_busy_mid", u_busy, 1);
    step();
    chk("u_c_valid", u_c_out_valid, 1);
    chk("u_c_data", u_c_out_data, 70);
    chk("u_last_err", u_last_err, 0);
    chk("u_fwd_drained", u_a_out_valid, 0);
    step();
    chk("u_c_consumed", u_c_out_valid, 0);
    chk("u_busy_done", u_busy, 0);

    // Signed wrap: (-128*-128)*2 + 1 = 32769 = 0x8001
    s_beat(8'h80, 8'h80, 1'b0, 1'b0);
    chk("s_state_accum", s_dbg_state, 1);
    s_beat(8'h80, 8'h80, 1'b0, 1'b0);
    s_beat(8'h01, 8'h01, 1'b1, 1'b1);
    s_idle();
    chk("s_state_idle", s_dbg_state, 0);
    step();
    chk("s_wrap_valid", s_c_out_valid, 1);
    chk("s_wrap_data", s_c_out_data, 16'h8001);

    // Single beat -3*5 = -15 = 0xFFF1
    s_beat(8'hFD, 8'h05, 1'b1, 1'b1);
    s_idle();
    step();
    chk("s_neg_valid", s_c_out_valid, 1);
    chk("s_neg_data", s_c_out_data, 16'hFFF1);
    step();

    // Back-to-back single-beat vectors: 6, 20, 42 on consecutive cycles
    s_beat(8'd2, 8'd3, 1'b1, 1'b1);
    s_beat(8'd4, 8'd5, 1'b1, 1'b1);
    chk("b2b_c0", s_c_out_data, 6);
    s_beat(8'd6, 8'd7, 1'b1, 1'b1);
    chk("b2b_c1", s_c_out_data, 20);
    chk("b2b_v1", s_c_out_valid, 1);
    s_idle();
    step();
    chk("b2b_c2", s_c_out_data, 42);
    chk("b2b_v2", s_c_out_valid, 1);
    step();

    // Forward back-pressure: both out registers full and held
    s_a_out_ready = 1'b0;
    s_b_out_ready = 1'b0;
    s_beat(8'd3, 8'd4, 1'b0, 1'b0);
    s_a_in_data = 8'd5; s_b_in_data = 8'd6; s_a_in_last = 1'b1; s_b_in_last = 1'b1;
    #1;
    chk("bp_a_ready", s_a_in_ready, 0);
    chk("bp_b_ready", s_b_in_ready, 0);
    step();
    step();
    chk("bp_hold_a", s_a_out_data, 3);
    chk("bp_hold_b", s_b_out_data, 4);
    chk("bp_hold_valid", s_a_out_valid, 1);
    s_a_out_ready = 1'b1;
    s_b_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", s_a_in_ready, 1);
    step();
    chk("bp_next_a", s_a_out_data, 5);
    chk("bp_next_b", s_b_out_data, 6);
    s_idle();
    step();
    chk("bp_c_data", s_c_out_data, 42);
    chk("bp_c_valid", s_c_out_valid, 1);
    step();

    // C back-pressure: second result waits in stage 1, input stalls
    s_c_out_ready = 1'b0;
    s_beat(8'd2, 8'd2, 1'b1, 1'b1);
    s_beat(8'd3, 8'd3, 1'b1, 1'b1);
    chk("cbp_first", s_c_out_data, 4);
    s_a_in_data = 8'd5; s_b_in_data = 8'd5;
    #1;
    chk("cbp_stall_ready", s_a_in_ready, 0);
    step();
    step();
    chk("cbp_hold_data", s_c_out_data, 4);
    chk("cbp_hold_valid", s_c_out_valid, 1);
    chk("cbp_no_fire", s_a_out_data, 3);
    chk("cbp_busy", s_busy, 1);
    s_c_out_ready = 1'b1;
    #1;
    chk("cbp_release_ready", s_a_in_ready, 1);
    step();
    chk("cbp_second", s_c_out_data, 9);
    chk("cbp_second_valid", s_c_out_valid, 1);
    s_idle();
    step();
    chk("cbp_third", s_c_out_data, 25);
    step();

    // Mismatched last: vector closes at beat 2, flag sticks
    s_beat(8'd1, 8'd2, 1'b0, 1'b0);
    chk("mm_err_before", s_last_err, 0);
    s_beat(8'd3, 8'd4, 1'b1, 1'b0);
    s_idle();
    chk("mm_err_set", s_last_err, 1);
    chk("mm_state_idle", s_dbg_state, 0);
    step();
    chk("mm_c_data", s_c_out_data, 14);
    chk("mm_c_valid", s_c_out_valid, 1);
    step();
    step();
    chk("mm_err_sticky", s_last_err, 1);

    // Reset mid-vector, then (1,1),(1,1) last gives 2
    s_beat(8'd7, 8'd7, 1'b0, 1'b0);
    s_beat(8'd7, 8'd7, 1'b0, 1'b0);
    s_idle();
    rst = 1'b1;
    step();
    chk("mr_c_valid", s_c_out_valid, 0);
    chk("mr_c_data", s_c_out_data, 0);
    chk("mr_a_out_valid", s_a_out_valid, 0);
    chk("mr_a_out_data", s_a_out_data, 0);
    chk("mr_busy", s_busy, 0);
    chk("mr_last_err", s_last_err, 0);
    chk("mr_ready", s_b_in_ready, 1);
    rst = 1'b0;
    step();
    s_beat(8'd1, 8'd1, 1'b0, 1'b0);
    s_beat(8'd1, 8'd1, 1'b1, 1'b1);
    s_idle();
    step();
    chk("mr_c_after", s_c_out_data, 2);
    chk("mr_c_after_valid", s_c_out_valid, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
